mem_responder: RTL and testbench

- Main-memory side of the cache hierarchy; the responder that L2 line-fill reads and write-through writes terminate at.
- Accepts one request at a time on a valid/ready request channel.
- Models a fixed access latency, then returns read data or a write acknowledgement on a valid/ready response channel.
- Keeps read and write counters and prints them on report.

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_array.sv | 25 ++
 rtl/mem_responder.sv | 112 +++++++++++
 tb/tb_mem_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory responder.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    localparam int unsigned LAT_W = 8;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Statistics counters stick at CNT_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage: synchronous write, combinational read, zero at time zero, no reset.
module mem_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Main-memory responder: one request at a time, fixed access latency, valid/ready response,
// saturating read/write statistics.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  report,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_write,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [CNT_W-1:0]      read_count,
    output logic [CNT_W-1:0]      write_count
);

    state_e                state;
    logic [LAT_W-1:0]      cnt;
    logic                  lat_write;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] arr_rdata;
    logic                  access;
    logic                  arr_we;

    // The access edge is the last WAIT edge; a reset drops the transaction before it.
    assign access = (state == WAIT) && (cnt == '0);
    assign arr_we = access && lat_write;

    mem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .addr (lat_addr),
        .wdata(lat_wdata),
        .rdata(arr_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_write  <= 1'b0;
            resp_rdata  <= '0;
            read_count  <= '0;
            write_count <= '0;
            cnt         <= '0;
            lat_write   <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        cnt       <= LAT_W'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - LAT_W'(1);
                    end else begin
                        if (lat_write) begin
                            resp_rdata  <= lat_wdata;
                            resp_write  <= 1'b1;
                            write_count <= sat_inc(write_count);
                        end else begin
                            resp_rdata  <= arr_rdata;
                            resp_write  <= 1'b0;
                            read_count  <= sat_inc(read_count);
                        end
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (report) begin
            $display("mem_responder %m: read_count=%0d write_count=%0d", read_count, write_count);
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder at LATENCY=4 and LATENCY=1 against a word-array reference.
module tb_mem_responder;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          report;
    logic          req_valid   [2];
    logic          req_ready   [2];
    logic          req_write   [2];
    logic [AW-1:0] req_addr    [2];
    logic [DW-1:0] req_wdata   [2];
    logic          resp_valid  [2];
    logic          resp_ready  [2];
    logic          resp_write  [2];
    logic [DW-1:0] resp_rdata  [2];
    logic [15:0]   read_count  [2];
    logic [15:0]   write_count [2];

    // Reference: one word array and two counters per instance.
    logic [DW-1:0] mem_m [2][256];
    int            rd_m [2];
    int            wr_m [2];
    time           last_acc [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .report(report),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_write(resp_write[0]),
        .resp_rdata(resp_rdata[0]), .read_count(read_count[0]), .write_count(write_count[0])
    );

    mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .report(report),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_write(resp_write[1]),
        .resp_rdata(resp_rdata[1]), .read_count(read_count[1]), .write_count(write_count[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counts(input int d, input string tag);
        chk({tag, "_rdcnt"}, 64'(read_count[d]), 64'(rd_m[d]));
        chk({tag, "_wrcnt"}, 64'(write_count[d]), 64'(wr_m[d]));
    endtask

    // One complete transaction; called at a negedge while the DUT is idle.
    task automatic txn(input int d, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input int stall, input logic poke);
        int n;
        time t_acc;
        logic [DW-1:0] exp_d;
        logic [DW-1:0] held;
        req_write[d] = wr;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_valid[d] = 1'b1;
        n = 0;
        while (!req_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", 64'(req_ready[d]), 64'(1));
        @(posedge clk);
        t_acc = $time;
        if (last_acc[d] != 0) begin
            chk("req_spacing", 64'((t_acc - last_acc[d]) >= time'((lat_of(d) + 1) * 10)), 64'(1));
        end
        last_acc[d] = t_acc;
        @(negedge clk);
        req_valid[d] = 1'b0;
        chk("accept_ready_low", 64'(req_ready[d]), 64'(0));
        n = 0;
        while (!resp_valid[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(lat_of(d)));
        if (wr) begin
            mem_m[d][a] = wd;
            exp_d = wd;
            if (wr_m[d] < 65535) wr_m[d]++;
        end else begin
            exp_d = mem_m[d][a];
            if (rd_m[d] < 65535) rd_m[d]++;
        end
        chk("resp_write", 64'(resp_write[d]), 64'(wr));
        chk("resp_rdata", 64'(resp_rdata[d]), 64'(exp_d));
        chk_counts(d, "access");
        if (!resp_ready[d]) begin
            held = resp_rdata[d];
            for (int i = 0; i < stall; i++) begin
                if (poke) req_valid[d] = 1'b1;
                @(negedge clk);
                chk("stall_valid", 64'(resp_valid[d]), 64'(1));
                chk("stall_rdata", 64'(resp_rdata[d]), 64'(held));
                chk("stall_ready", 64'(req_ready[d]), 64'(0));
            end
            req_valid[d]  = 1'b0;
            resp_ready[d] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            resp_ready[d] = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("after_hs_valid", 64'(resp_valid[d]), 64'(0));
        chk("after_hs_ready", 64'(req_ready[d]), 64'(1));
        chk_counts(d, "after_hs");
    endtask

    initial begin
        logic [DW-1:0] rdat;
        int n;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) mem_m[d][i] = '0;
            rd_m[d] = 0; wr_m[d] = 0; last_acc[d] = 0;
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; resp_ready[d] = 1'b0;
        end
        report = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", 64'(req_ready[d]), 64'(1));
            chk("rst_resp_valid", 64'(resp_valid[d]), 64'(0));
            chk_counts(d, "rst");
        end

        // Directed write then read-after-write at LATENCY=4.
        txn(0, 1'b1, 8'h10, 32'hDEADBEEF, 1, 1'b0);
        txn(0, 1'b0, 8'h10, 32'h0, 1, 1'b0);
        chk("raw_data", 64'(resp_rdata[0]), 64'(32'hDEADBEEF));

        // Long stall on an unwritten word, with a stray request during the stall.
        txn(0, 1'b0, 8'h20, $urandom, 10, 1'b1);

        // Reset in the second WAIT cycle drops the write.
        req_write[0] = 1'b1; req_addr[0] = 8'h30; req_wdata[0] = 32'hA5A5_1234;
        req_valid[0] = 1'b1;
        n = 0;
        while (!req_ready[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("drop_req_ready", 64'(req_ready[0]), 64'(1));
        chk("drop_resp_valid", 64'(resp_valid[0]), 64'(0));
        chk("drop_resp_write", 64'(resp_write[0]), 64'(0));
        chk("drop_resp_rdata", 64'(resp_rdata[0]), 64'(0));
        for (int d = 0; d < 2; d++) begin
            rd_m[d] = 0; wr_m[d] = 0; last_acc[d] = 0;
        end
        chk_counts(0, "drop");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        txn(0, 1'b0, 8'h30, 32'h0, 0, 1'b0);
        chk("drop_old_data", 64'(resp_rdata[0]), 64'(0));

        // Random traffic at LATENCY=4 over a small address window to force address reuse.
        for (int i = 0; i < 30; i++) begin
            txn(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // LATENCY=1 with resp_ready tied high, alternating the two extreme addresses.
        resp_ready[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rdat = $urandom;
            txn(1, 1'b1, 8'hFF, rdat, 0, 1'b0);
            txn(1, 1'b1, 8'h00, ~rdat, 0, 1'b0);
            txn(1, 1'b0, 8'hFF, 32'h0, 0, 1'b0);
            txn(1, 1'b0, 8'h00, 32'h0, 0, 1'b0);
        end
        resp_ready[1] = 1'b0;

        // Saturation: preload write_count near the top, then keep writing.
        force dut1.write_count = 16'hFFFE;
        @(negedge clk);
        release dut1.write_count;
        wr_m[1] = 32'hFFFE;
        @(negedge clk);
        chk("sat_preload", 64'(write_count[1]), 64'(16'hFFFE));
        for (int i = 0; i < 3; i++) begin
            txn(1, 1'b1, 8'($urandom_range(0, 255)), $urandom, 0, 1'b0);
        end
        chk("sat_hold", 64'(write_count[1]), 64'(16'hFFFF));

        // report only prints; state must not move.
        report = 1'b1;
        repeat (2) @(negedge clk);
        report = 1'b0;
        chk_counts(0, "report");
        chk_counts(1, "report");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
